// File: rtl/score_counter.sv
// Game score counter: IDLE/RUN/OVER FSM, frame-tick prescaler, saturating score,
// hundreds milestone pulse and best-score tracking.
module score_counter #(
  parameter int unsigned TICKS_PER_POINT = 6,
  parameter int unsigned MAX_SCORE       = 99999
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        collide,
  output logic [16:0] curr_score,
  output logic [16:0] high_score,
  output logic        running,
  output logic        game_over,
  output logic        milestone,
  output logic        new_high
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_e;

  localparam logic [5:0]  TICK_LAST = 6'(TICKS_PER_POINT - 1);
  localparam logic [16:0] MAX_Q     = 17'(MAX_SCORE);

  state_e      state_q, state_d;
  logic [5:0]  tick_q, tick_d;
  logic [16:0] score_q, score_d;
  logic [16:0] high_q, high_d;
  logic [6:0]  sub_q, sub_d;
  logic        milestone_q, milestone_d;
  logic        new_high_q, new_high_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      score_q     <= '0;
      high_q      <= '0;
      sub_q       <= '0;
      milestone_q <= 1'b0;
      new_high_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      score_q     <= score_d;
      high_q      <= high_d;
      sub_q       <= sub_d;
      milestone_q <= milestone_d;
      new_high_q  <= new_high_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    score_d     = score_q;
    high_d      = high_q;
    sub_d       = sub_q;
    new_high_d  = new_high_q;
    milestone_d = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d    = RUN;
          tick_d     = '0;
          score_d    = '0;
          sub_d      = '0;
          new_high_d = 1'b0;
        end
      end
      RUN: begin
        // Collision takes priority over a coinciding score increment
        if (collide) begin
          state_d = OVER;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end else begin
            new_high_d = 1'b0;
          end
        end else if (frame_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (score_q < MAX_Q) begin
              score_d = score_q + 17'd1;
              if (sub_q == 7'd99) begin
                sub_d       = '0;
                milestone_d = 1'b1;
              end else begin
                sub_d = sub_q + 7'd1;
              end
            end
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign curr_score = score_q;
  assign high_score = high_q;
  assign running    = (state_q == RUN);
  assign game_over  = (state_q == OVER);
  assign milestone  = milestone_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_score_counter.sv
// Directed self-checking bench for score_counter: a default instance plus a
// MAX_SCORE=105 instance driven with the same stimulus for the saturation case.
module tb_score_counter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        collide = 1'b0;

  logic [16:0] curr_score, high_score;
  logic        running, game_over, milestone, new_high;
  logic [16:0] sat_curr_score, sat_high_score;
  logic        sat_running, sat_game_over, sat_milestone, sat_new_high;

  int num_checks = 0;
  int num_errors = 0;
  int ms_count;
  int ms_score;
  int sat_ms_count;

  always #5 clk = ~clk;

  score_counter dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start(start),
    .collide(collide), .curr_score(curr_score), .high_score(high_score),
    .running(running), .game_over(game_over), .milestone(milestone),
    .new_high(new_high)
  );

  score_counter #(.TICKS_PER_POINT(6), .MAX_SCORE(105)) dut_sat (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start(start),
    .collide(collide), .curr_score(sat_curr_score), .high_score(sat_high_score),
    .running(sat_running), .game_over(sat_game_over), .milestone(sat_milestone),
    .new_high(sat_new_high)
  );

  // One comparison point: counts it and reports observed/expected on failure
  task automatic checkOutput(input string tag, input int obs, input int exp);
    num_checks++;
    assert (obs === exp) else begin
      num_errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive frame_tick for n consecutive cycles while recording milestone pulses
  task automatic applyStimulus(input int n);
    ms_count     = 0;
    ms_score     = -1;
    sat_ms_count = 0;
    frame_tick   = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      if (milestone) begin
        ms_count++;
        ms_score = int'(curr_score);
      end
      if (sat_milestone) sat_ms_count++;
    end
    frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_collide();
    collide = 1'b1;
    step();
    collide = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    checkOutput("rst_curr",      int'(curr_score), 0);
    checkOutput("rst_high",      int'(high_score), 0);
    checkOutput("rst_running",   int'(running),    0);
    checkOutput("rst_game_over", int'(game_over),  0);
    checkOutput("rst_milestone", int'(milestone),  0);
    checkOutput("rst_new_high",  int'(new_high),   0);
    step();
    resetn = 1'b1;

    // IDLE ignores frame_tick and collide
    collide = 1'b1;
    applyStimulus(12);
    collide = 1'b0;
    checkOutput("idle_curr",    int'(curr_score), 0);
    checkOutput("idle_running", int'(running),    0);
    checkOutput("idle_over",    int'(game_over),  0);

    // Run A: 60 ticks -> 10 points, no milestone
    pulse_start();
    checkOutput("runA_running", int'(running),    1);
    checkOutput("runA_curr0",   int'(curr_score), 0);
    applyStimulus(60);
    checkOutput("runA_curr10",  int'(curr_score), 10);
    checkOutput("runA_run10",   int'(running),    1);
    checkOutput("runA_ms10",    ms_count,         0);

    // 540 more ticks reach 100: exactly one milestone, coincident with 100
    applyStimulus(540);
    checkOutput("runA_curr100",  int'(curr_score), 100);
    checkOutput("runA_ms_count", ms_count,         1);
    checkOutput("runA_ms_score", ms_score,         100);
    step();
    checkOutput("runA_ms_drop",  int'(milestone),  0);

    pulse_collide();
    checkOutput("runA_over",     int'(game_over),  1);
    checkOutput("runA_notrun",   int'(running),    0);
    checkOutput("runA_high",     int'(high_score), 100);
    checkOutput("runA_new_high", int'(new_high),   1);
    collide = 1'b1;
    applyStimulus(12);
    collide = 1'b0;
    checkOutput("over_hold_curr", int'(curr_score), 100);
    checkOutput("over_hold_over", int'(game_over),  1);

    // Run B: reset pulsed between edges at score 77
    pulse_start();
    checkOutput("runB_new_high_clr", int'(new_high), 0);
    applyStimulus(462);
    checkOutput("runB_curr77", int'(curr_score), 77);
    resetn = 1'b0;
    #2;
    checkOutput("async_curr",      int'(curr_score), 0);
    checkOutput("async_high",      int'(high_score), 0);
    checkOutput("async_running",   int'(running),    0);
    checkOutput("async_game_over", int'(game_over),  0);
    checkOutput("async_milestone", int'(milestone),  0);
    checkOutput("async_new_high",  int'(new_high),   0);
    #1;
    resetn = 1'b1;
    step();
    step();
    checkOutput("post_rst_idle", int'(running), 0);

    // Run C: score 42, collide on the 6th tick of the next point
    pulse_start();
    applyStimulus(252);
    checkOutput("runC_curr42", int'(curr_score), 42);
    applyStimulus(5);
    frame_tick = 1'b1;
    collide    = 1'b1;
    step();
    frame_tick = 1'b0;
    collide    = 1'b0;
    checkOutput("runC_over",     int'(game_over),  1);
    checkOutput("runC_curr",     int'(curr_score), 42);
    checkOutput("runC_high",     int'(high_score), 42);
    checkOutput("runC_new_high", int'(new_high),   1);

    // Run D: start and collide together in OVER, start wins
    start   = 1'b1;
    collide = 1'b1;
    step();
    start   = 1'b0;
    collide = 1'b0;
    checkOutput("runD_running",  int'(running),    1);
    checkOutput("runD_over",     int'(game_over),  0);
    checkOutput("runD_curr",     int'(curr_score), 0);
    checkOutput("runD_new_high", int'(new_high),   0);
    applyStimulus(60);
    pulse_start();
    checkOutput("runD_restart_ign", int'(curr_score), 10);
    checkOutput("runD_still_run",   int'(running),    1);
    applyStimulus(120);
    pulse_collide();
    checkOutput("runD_curr30",   int'(curr_score), 30);
    checkOutput("runD_high",     int'(high_score), 42);
    checkOutput("runD_new_high0", int'(new_high),  0);

    // Run E: ties the high score, which is not a new high
    pulse_start();
    applyStimulus(252);
    pulse_collide();
    checkOutput("runE_curr",     int'(curr_score), 42);
    checkOutput("runE_high",     int'(high_score), 42);
    checkOutput("runE_new_high", int'(new_high),   0);

    // Run F: 700 ticks; the MAX_SCORE=105 instance saturates
    pulse_start();
    applyStimulus(700);
    checkOutput("sat_curr",     int'(sat_curr_score), 105);
    checkOutput("sat_ms_count", sat_ms_count,         1);
    checkOutput("dflt_curr",    int'(curr_score),     116);
    checkOutput("dflt_ms",      ms_count,             1);
    applyStimulus(12);
    checkOutput("sat_hold",     int'(sat_curr_score), 105);
    checkOutput("sat_ms_none",  sat_ms_count,         0);
    pulse_collide();
    checkOutput("sat_high",     int'(sat_high_score), 105);
    checkOutput("dflt_high",    int'(high_score),     118);

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
